// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : op codes and FSM state encoding shared by the sequential ALU.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu32_seq_slice.sv
// ---------------------------------------------------------------------------
// alu32_seq_slice : combinational 16-bit ALU slice (and/or/add/slt, b-invert).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu32_seq_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        less,
  input  logic [2:0]  op,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        set,
  output logic        zero
);

  logic [15:0] bb;
  logic [16:0] sum;

  assign bb   = op[2] ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
  assign cout = sum[16];
  assign set  = sum[15];
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf  = (a[15] == bb[15]) && (sum[15] != a[15]);

  always_comb begin
    result = 16'b0;
    case (op[1:0])
      2'b00:   result = a & bb;
      2'b01:   result = a | bb;
      2'b10:   result = sum[15:0];
      default: result = {15'b0, less};
    endcase
  end

  assign zero = (result == 16'b0);

endmodule

`default_nettype wire

// File: rtl/alu32_seq.sv
// ---------------------------------------------------------------------------
// alu32_seq : 32-bit ALU built from one 16-bit slice used over two cycles.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu32_seq
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         cout
);

  localparam int H = W / 2;

  state_t       state, state_nx;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic [H-1:0] res_lo;
  logic         c16, zero_lo;

  logic [H-1:0] sl_a, sl_b, sl_res;
  logic         sl_cin, sl_cout, sl_ovf, sl_set, sl_zero;
  logic         slt_bit, arith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nx = ST_LO;
      ST_LO:                  state_nx = ST_HI;
      ST_HI:                  state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Operand muxes: the low half and op[2] carry-in in LO, the high half and c16 otherwise.
  assign sl_a   = (state == ST_HI) ? a_q[W-1:H] : a_q[H-1:0];
  assign sl_b   = (state == ST_HI) ? b_q[W-1:H] : b_q[H-1:0];
  assign sl_cin = (state == ST_HI) ? c16 : op_q[2];

  alu32_seq_slice u_slice (
    .a      (sl_a),
    .b      (sl_b),
    .cin    (sl_cin),
    .less   (1'b0),
    .op     (op_q),
    .result (sl_res),
    .cout   (sl_cout),
    .ovf    (sl_ovf),
    .set    (sl_set),
    .zero   (sl_zero)
  );

  assign slt_bit = sl_set ^ sl_ovf;
  assign arith   = is_arith(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b0;
      res_lo   <= '0;
      c16      <= 1'b0;
      zero_lo  <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      cout     <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (state == ST_LO) begin
        res_lo  <= sl_res;
        c16     <= sl_cout;
        zero_lo <= sl_zero;
      end
      // Outputs assemble straight from the high pass and then hold through DONE.
      if (state == ST_HI) begin
        if (op_q == ALU_SLT) begin
          result <= {{(W-1){1'b0}}, slt_bit};
          zero   <= ~slt_bit;
        end else begin
          result <= {sl_res, res_lo};
          zero   <= zero_lo & sl_zero;
        end
        overflow <= arith & sl_ovf;
        cout     <= arith & sl_cout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu32_seq.sv
// ---------------------------------------------------------------------------
// tb_alu32_seq : directed self-checking bench for alu32_seq.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = 3'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, overflow, cout;

  int checks = 0;
  int errors = 0;

  alu32_seq #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at edge E0; out_valid must be low after E0 and E1 and high after E2.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic ez,
                        input logic eo, input logic ec);
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lo_valid"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".hi_valid"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".result"},    result,              er);
    chk({tag, ".zero"},      {31'b0, zero},       {31'b0, ez});
    chk({tag, ".overflow"},  {31'b0, overflow},   {31'b0, eo});
    chk({tag, ".cout"},      {31'b0, cout},       {31'b0, ec});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst.in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.result",    result,             32'd0);
    chk("rst.flags",     {29'b0, zero, overflow, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_c16",  3'b010, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq",   3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",  3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("slt_neg",  3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1);
    run_op("slt_pos",  3'b111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("and",      3'b000, 32'hF0F0FFFF, 32'h0FF0000F, 32'h00F0000F, 1'b0, 1'b0, 1'b0);
    run_op("or",       3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0);
    run_op("andn_raw", 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE while a new request waits.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; a = 32'd10; b = 32'd20;
    @(negedge clk);
    op = 3'b110; a = 32'd100; b = 32'd1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp.out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp.in_ready",  {31'b0, in_ready},  32'd0);
      chk("bp.result",    result,             32'd30);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.idle_valid", {31'b0, out_valid}, 32'd0);
    chk("bp.idle_ready", {31'b0, in_ready},  32'd1);
    chk("bp.idle_result", result,            32'd30);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.accepted", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp.hi_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("bp2.out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp2.result",    result,             32'd99);
    chk("bp2.cout",      {31'b0, cout},      32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted during HI clears the previous registered outputs at once.
    in_valid = 1'b1; op = 3'b010; a = 32'h12345678; b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.in_ready",  {31'b0, in_ready},  32'd1);
    chk("mid_rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst.result",    result,             32'd0);
    chk("mid_rst.flags",     {29'b0, zero, overflow, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'b010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu32_seq.md
# alu32_seq

Sequential 32-bit ALU front end that sits directly upstream of the 16-bit ALU slice. It feeds the slice the low half and then the high half of a 32-bit operation over two cycles, chaining the carry between them. It assembles the 32-bit result and flags, and presents them downstream on a valid/ready handshake. This is the area-saving 32-bit execution path: one 16-bit slice, time-multiplexed, instead of two.

## Interface
Parameters:
- `W`, 32: operand width; fixed at 32, two 16-bit passes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  32  operands, sampled on accept.
- `op`  in  3  operation; sampled on accept.
- `out_valid`  out  1  result valid; held until consumed.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  32  assembled result.
- `zero`  out  1  result == 0.
- `overflow`  out  1  signed overflow, arithmetic ops only.
- `cout`  out  1  carry out of bit 31, arithmetic ops only.

## Operation
- Op codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `op[2]` is b-invert and the initial carry-in. Codes 011/100/101 are passed through to the slice unchanged; `overflow` and `cout` are reported 0 for them.
- FSM has four states: IDLE, LO, HI, DONE.
- IDLE → LO on `in_valid & in_ready`. Latch `a`, `b`, `op`.
- LO: drive the slice with `a_q[15:0]`, `b_q[15:0]`, `cin=op_q[2]`, `less=0`. At the end of LO, capture `res_lo`, carry `c16`, `zero_lo`. Go to HI.
- HI: drive the slice with `a_q[31:16]`, `b_q[31:16]`, `cin=c16`, `less=0`. At the end of HI, capture `res_hi`, `cout_hi`, `ovf_hi`, `set_hi`, `zero_hi`. Go to DONE.
- DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- Result assembly:
  - Non-SLT: `result={res_hi,res_lo}`, `zero=zero_lo&zero_hi`.
  - SLT: `result={31'b0, set_hi^ovf_hi}` (correct signed compare), `zero=~(set_hi^ovf_hi)`.
- `overflow=ovf_hi` and `cout=cout_hi` for 010/110/111; both are 0 otherwise.
- Outputs are registered and stable throughout DONE. They are not updated until the next operation completes HI.

## Timing
- Accept at edge E0. LO occupies the cycle after E0, HI the next. `out_valid` rises after E2, i.e. two cycles after the accept edge.
- Minimum throughput is one op per 4 cycles (IDLE, LO, HI, DONE). `in_ready` is 0 in LO, HI and DONE. `in_valid` is ignored when `in_ready=0`.
- `out_valid` stays high and `result`/flags stay constant while `out_ready=0`; there is no timeout.
- Reset values: state IDLE, `out_valid=0`, `result=0`, `zero=0`, `overflow=0`, `cout=0`, internal latches 0. `in_ready=1` as soon as `rst_n` is low, since it is decoded from IDLE.
- Reset mid-operation (LO/HI/DONE) aborts immediately. No partial result is presented, and the next accepted op behaves as if from power-up.
- The slice is purely combinational. Its inputs must settle within one cycle; there is no multicycle path.

## Structure
- Shared package `alu_pkg`: op-code localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`) and the state encoding (IDLE/LO/HI/DONE).
- One sub-module: a single instance of the existing 16-bit ALU slice, with operand muxes on its inputs selected by state. No second slice and no separate FSM module.

## Test plan
- ADD `0x0000FFFF + 0x00000001` → `result=0x00010000`, `cout=0`, `overflow=0`, `zero=0`. Proves the c16 chain; `out_valid` rises exactly two cycles after accept.
- SUB `0x00000005 - 0x00000005` → `result=0`, `zero=1`, `cout=1`, `overflow=0`.
- ADD `0x7FFFFFFF + 0x00000001` → `result=0x80000000`, `overflow=1`, `cout=0`.
- SLT `0x80000000` vs `0x00000001` → `result=1`, `zero=0`. SLT `0x00000005` vs `0x00000003` → `result=0`, `zero=1`. AND `0xF0F0FFFF & 0x0FF0000F` → `0x00F0000F`, `overflow=0`, `cout=0`.
- Backpressure: hold `out_ready=0` for 3 cycles in DONE while `in_valid=1` with new operands → result held, `in_ready=0`, new request not taken. It is accepted in the cycle after the `out_ready` handshake returns the FSM to IDLE.
- Drop `rst_n` during HI → all outputs reset asynchronously, `in_ready=1`. A following ADD `1+2` returns `3` with correct latency.
